// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns ({CG..CA}, active-low), digit codes,
// scan-reader FSM states and the anode qualification helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Returns {valid, idx}: valid only when exactly one active-low anode is driven.
    function automatic logic [3:0] an_qualify(input logic [7:0] an);
        logic [3:0] zeros;
        logic [2:0] idx;
        zeros = 4'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                zeros = zeros + 4'd1;
                idx   = 3'(i);
            end
        end
        return {(zeros == 4'd1), idx};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: {CG..CA} to BCD value with blank/error flags.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       blank,
    output logic       err
);

    // Pattern lookup; anything not in the table is flagged as an error.
    always_comb begin
        value = DIG_ERR;
        blank = 1'b0;
        err   = 1'b0;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: begin
                value = DIG_BLANK;
                blank = 1'b1;
            end
            default: begin
                value = DIG_ERR;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers the 8 displayed digits from an active-low 7-segment bus (static or multiplexed)
// once anodes and segments have been stable for SETTLE_CYCLES synchronized cycles.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CA,
    input  logic        CB,
    input  logic        CC,
    input  logic        CD,
    input  logic        CE,
    input  logic        CF,
    input  logic        CG,
    input  logic        AN0,
    input  logic        AN1,
    input  logic        AN2,
    input  logic        AN3,
    input  logic        AN4,
    input  logic        AN5,
    input  logic        AN6,
    input  logic        AN7,
    output logic [31:0] DIGITS,
    output logic [7:0]  BLANK,
    output logic [7:0]  ERR,
    output logic        UPD,
    output logic [2:0]  UPD_IDX
);

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

    logic [14:0] pins_s;
    logic [14:0] sync1_q;
    logic [14:0] sync2_q;
    logic [6:0]  seg_s;
    logic [7:0]  an_s;
    logic [3:0]  qual_s;
    logic        an_chg_s;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  an_ref_q, an_ref_d;
    logic [6:0]  seg_ref_q, seg_ref_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  blank_q, blank_d;
    logic [7:0]  err_q, err_d;
    logic        upd_q, upd_d;
    logic [2:0]  upd_idx_q, upd_idx_d;

    logic [3:0]  dec_value_s;
    logic        dec_blank_s;
    logic        dec_err_s;

    assign pins_s = {AN7, AN6, AN5, AN4, AN3, AN2, AN1, AN0, CG, CF, CE, CD, CC, CB, CA};
    assign seg_s  = sync2_q[6:0];
    assign an_s   = sync2_q[14:7];
    assign qual_s = an_qualify(an_s);

    seg7_decode u_decode (
        .seg   (seg_ref_q),
        .value (dec_value_s),
        .blank (dec_blank_s),
        .err   (dec_err_s)
    );

    // Two-flop synchronizer, preset to the inactive (all-high) bus level.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q <= 15'h7FFF;
            sync2_q <= 15'h7FFF;
        end else begin
            sync1_q <= pins_s;
            sync2_q <= sync1_q;
        end
    end

    // Next-state: IDLE is treated as "anode changed" so all states share the re-qualify path.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        an_ref_d  = an_ref_q;
        seg_ref_d = seg_ref_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        err_d     = err_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        an_chg_s  = (state_q == ST_IDLE) || (an_s != an_ref_q);

        if (an_chg_s) begin
            if (qual_s[3]) begin
                state_d   = ST_SETTLE;
                idx_d     = qual_s[2:0];
                an_ref_d  = an_s;
                seg_ref_d = seg_s;
                cnt_d     = 8'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (seg_s != seg_ref_q) begin
            state_d   = ST_SETTLE;
            seg_ref_d = seg_s;
            cnt_d     = 8'd1;
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q >= SETTLE_LIM) begin
                state_d                      = ST_HOLD;
                digits_d[{idx_q, 2'b00} +: 4] = dec_value_s;
                blank_d[idx_q]               = dec_blank_s;
                err_d[idx_q]                 = dec_err_s;
                upd_d                        = 1'b1;
                upd_idx_d                    = idx_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (state_q == ST_HOLD) begin
            state_d = ST_HOLD;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State, capture and output registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            an_ref_q  <= 8'hFF;
            seg_ref_q <= 7'h7F;
            cnt_q     <= 8'd0;
            digits_q  <= 32'hFFFF_FFFF;
            blank_q   <= 8'hFF;
            err_q     <= 8'h00;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            an_ref_q  <= an_ref_d;
            seg_ref_q <= seg_ref_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign DIGITS  = digits_q;
    assign BLANK   = blank_q;
    assign ERR     = err_q;
    assign UPD     = upd_q;
    assign UPD_IDX = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: a pin-level run-length model predicts each
// digit write and its UPD edge; a monitor checks every UPD against the queued prediction.
module tb_seg7_scan_reader;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  an_drv;
    logic [6:0]  seg_drv;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  err;
    logic        upd;
    logic [2:0]  upd_idx;

    typedef struct {
        int         edge_no;
        int         idx;
        logic [3:0] val;
        logic       b;
        logic       e;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         upd_seen = 0;
    logic [6:0] pat [10];
    logic [3:0] shadow_dig [8];
    logic [7:0] shadow_blank;
    logic [7:0] shadow_err;

    seg7_scan_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .CLK(clk), .RSTN(rstn),
        .CA(seg_drv[0]), .CB(seg_drv[1]), .CC(seg_drv[2]), .CD(seg_drv[3]),
        .CE(seg_drv[4]), .CF(seg_drv[5]), .CG(seg_drv[6]),
        .AN0(an_drv[0]), .AN1(an_drv[1]), .AN2(an_drv[2]), .AN3(an_drv[3]),
        .AN4(an_drv[4]), .AN5(an_drv[5]), .AN6(an_drv[6]), .AN7(an_drv[7]),
        .DIGITS(digits), .BLANK(blank), .ERR(err), .UPD(upd), .UPD_IDX(upd_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] s, output logic [3:0] v,
                                       output logic b, output logic e);
        v = 4'hE; b = 1'b0; e = 1'b1;
        if (s == 7'h7F) begin v = 4'hF; b = 1'b1; e = 1'b0; end
        for (int k = 0; k < 10; k++)
            if (pat[k] == s) begin v = 4'(k); e = 1'b0; end
    endfunction

    function automatic logic [31:0] shadow_pack();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = shadow_dig[k];
        return r;
    endfunction

    // Reference model: a valid pin vector held for SETTLE+1 sampled edges is written,
    // with UPD two edges later (synchronizer delay).
    initial begin : model
        logic [14:0] prev, cur;
        int          run, idx;
        logic [3:0]  v;
        logic        b, e;
        prev = 15'h7FFF;
        run  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                run = 0;
                exp_q.delete();
                for (int k = 0; k < 8; k++) shadow_dig[k] = 4'hF;
                shadow_blank = 8'hFF;
                shadow_err   = 8'h00;
            end else begin
                cur = {an_drv, seg_drv};
                if (run > 0 && cur == prev) run++;
                else run = 1;
                prev = cur;
                if (run == SETTLE + 1 && $countones(~an_drv) == 1) begin
                    idx = 0;
                    for (int k = 0; k < 8; k++) if (!an_drv[k]) idx = k;
                    ref_decode(seg_drv, v, b, e);
                    exp_q.push_back('{cyc + 2, idx, v, b, e});
                end
            end
        end
    end

    // Monitor: every UPD must match the head of the queue, at the predicted edge.
    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (rstn && upd) begin
                upd_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_upd: got UPD idx %0d expected none (cycle %0d)", upd_idx, cyc);
                end else begin
                    ex = exp_q.pop_front();
                    check("upd_edge", 32'(cyc), 32'(ex.edge_no));
                    check("upd_idx", 32'(upd_idx), 32'(ex.idx));
                    shadow_dig[ex.idx]   = ex.val;
                    shadow_blank[ex.idx] = ex.b;
                    shadow_err[ex.idx]   = ex.e;
                    check("digits", digits, shadow_pack());
                    check("blank", 32'(blank), 32'(shadow_blank));
                    check("err", 32'(err), 32'(shadow_err));
                end
            end else if (rstn && exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
                n_checks++; n_fail++;
                $display("FAIL missing_upd: got no UPD expected idx %0d at edge %0d (cycle %0d)",
                         exp_q[0].idx, exp_q[0].edge_no, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
        an_drv  = a;
        seg_drv = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         base;
        logic [7:0] a;
        logic [6:0] s;
        int         r;
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0010000;
        rstn = 1'b1; an_drv = 8'hFF; seg_drv = 7'h7F;
        #1 rstn = 1'b0;
        #1;
        check("reset_digits", digits, 32'hFFFF_FFFF);
        check("reset_blank", 32'(blank), 32'hFF);
        check("reset_err", 32'(err), 32'h00);
        check("reset_upd", 32'(upd), 32'h0);
        check("reset_upd_idx", 32'(upd_idx), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Static single digit.
        base = upd_seen;
        drive(8'hFE, pat[7], 30);
        check("static_upd_count", 32'(upd_seen - base), 32'd1);
        check("static_dig0", 32'(digits[3:0]), 32'd7);
        check("static_blank0", 32'(blank[0]), 32'd0);

        // Counter loopback on digit 0.
        base = upd_seen;
        for (int k = 0; k <= 10; k++) begin
            drive(8'hFE, pat[k % 10], 20);
            check("counter_dig0", 32'(digits[3:0]), 32'(k % 10));
        end
        check("counter_upd_count", 32'(upd_seen - base), 32'd11);

        // Multiplexed scan showing 1..8.
        for (int i = 0; i < 8; i++) drive(~(8'h01 << i), pat[i + 1], 16);
        drive(8'hFF, 7'h7F, 10);
        check("scan_digits", digits, 32'h8765_4321);
        check("scan_blank", 32'(blank), 32'h00);
        check("scan_err", 32'(err), 32'h00);

        // Glitches: short single anode, then two anodes at once.
        base = upd_seen;
        drive(8'hF7, pat[5], 3);
        drive(8'hFF, 7'h7F, 10);
        drive(8'hBB, pat[6], 20);
        drive(8'hFF, 7'h7F, 10);
        check("glitch_upd_count", 32'(upd_seen - base), 32'd0);
        check("glitch_digits", digits, 32'h8765_4321);

        // Error then recovery on digit 5.
        drive(8'hDF, 7'b0101010, 20);
        check("err5_set", 32'(err[5]), 32'd1);
        check("err5_value", 32'(digits[23:20]), 32'hE);
        drive(8'hDF, 7'b0100100, 20);
        check("err5_clear", 32'(err[5]), 32'd0);
        check("err5_value2", 32'(digits[23:20]), 32'd2);
        drive(8'hDF, 7'h7F, 20);
        check("blank5_set", 32'(blank[5]), 32'd1);
        check("blank5_value", 32'(digits[23:20]), 32'hF);
        drive(8'hFF, 7'h7F, 10);

        // Reset in the middle of a settle on digit 1.
        drive(8'hFD, pat[3], 3);
        #2 rstn = 1'b0;
        #1;
        check("midrst_digits", digits, 32'hFFFF_FFFF);
        check("midrst_blank", 32'(blank), 32'hFF);
        check("midrst_err", 32'(err), 32'h00);
        check("midrst_upd", 32'(upd), 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        base = upd_seen;
        drive(8'hFD, pat[3], 20);
        check("postrst_upd_count", 32'(upd_seen - base), 32'd1);
        check("postrst_digits", digits, 32'hFFFF_FF3F);

        // Randomized bus activity.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = ~(8'h01 << $urandom_range(0, 7));
            else if (r < 8) a = 8'hFF;
            else            a = 8'($urandom);
            r = $urandom_range(0, 11);
            if (r < 10)       s = pat[r];
            else if (r == 10) s = 7'h7F;
            else              s = 7'($urandom);
            drive(a, s, $urandom_range(1, 12));
        end
        drive(8'hFF, 7'h7F, 20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
